// File: rtl/digit_scan_if.sv
// rtl/digit_scan_if.sv - scan controller control and decoder-drive bundle
interface digit_scan_if;
    logic        run;
    logic [3:0]  digit_mask;
    logic [15:0] value;
    logic        sel_a;
    logic        sel_b;
    logic        sel_e_n;
    logic [3:0]  nibble;
    logic        frame_done;

    modport master (
        output run, digit_mask, value,
        input  sel_a, sel_b, sel_e_n, nibble, frame_done
    );

    modport slave (
        input  run, digit_mask, value,
        output sel_a, sel_b, sel_e_n, nibble, frame_done
    );
endinterface

// File: rtl/digit_scan_ctrl.sv
// rtl/digit_scan_ctrl.sv - 4-digit time-multiplexed display scanner
// Drives a 2x4 active-low decoder with on/blank timing per enabled digit.
module digit_scan_ctrl #(
    parameter int ON_CYC    = 50000,
    parameter int BLANK_CYC = 500,
    parameter int CNT_W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    digit_scan_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYC - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK_CYC > 0) ? CNT_W'(BLANK_CYC - 1) : '0;

    state_t           state;
    logic [1:0]       idx;
    logic [3:0]       nibble;
    logic             sel_e_n;
    logic             frame_done;
    logic [CNT_W-1:0] cnt;

    logic             active;
    logic [1:0]       low_idx;
    logic [1:0]       nxt_idx;
    logic             nxt_wrap;
    logic [2:0]       sum;

    assign active = bus.run && (bus.digit_mask != 4'd0);

    // Lowest enabled digit, and the next enabled digit circularly above idx.
    // Offset 4 lands back on idx itself, which covers the single-digit case.
    always_comb begin
        low_idx  = 2'd0;
        nxt_idx  = idx;
        nxt_wrap = 1'b1;
        sum      = 3'd0;
        for (int i = 3; i >= 0; i--) begin
            if (bus.digit_mask[i]) low_idx = 2'(i);
        end
        for (int k = 4; k >= 1; k--) begin
            sum = {1'b0, idx} + 3'(k);
            if (bus.digit_mask[sum[1:0]]) begin
                nxt_idx  = sum[1:0];
                nxt_wrap = (sum[1:0] <= idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= 2'd0;
            nibble     <= 4'd0;
            sel_e_n    <= 1'b1;
            frame_done <= 1'b0;
            cnt        <= '0;
        end else begin
            frame_done <= 1'b0;
            if (!active) begin
                state   <= IDLE;
                idx     <= 2'd0;
                sel_e_n <= 1'b1;
                cnt     <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state   <= SHOW;
                        idx     <= low_idx;
                        nibble  <= bus.value[{low_idx, 2'b00} +: 4];
                        sel_e_n <= 1'b0;
                        cnt     <= '0;
                    end
                    SHOW: begin
                        if (cnt == ON_LAST) begin
                            if (BLANK_CYC > 0) begin
                                state   <= BLANK;
                                sel_e_n <= 1'b1;
                                cnt     <= '0;
                            end else begin
                                idx        <= nxt_idx;
                                nibble     <= bus.value[{nxt_idx, 2'b00} +: 4];
                                frame_done <= nxt_wrap;
                                cnt        <= '0;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    BLANK: begin
                        if (cnt == BLANK_LAST) begin
                            state      <= SHOW;
                            idx        <= nxt_idx;
                            nibble     <= bus.value[{nxt_idx, 2'b00} +: 4];
                            sel_e_n    <= 1'b0;
                            frame_done <= nxt_wrap;
                            cnt        <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        sel_e_n <= 1'b1;
                        cnt     <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.sel_a      = idx[1];
    assign bus.sel_b      = idx[0];
    assign bus.sel_e_n    = sel_e_n;
    assign bus.nibble     = nibble;
    assign bus.frame_done = frame_done;
endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb/tb_digit_scan_ctrl.sv - directed bench for digit_scan_ctrl (with and without blanking)
module tb_digit_scan_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    digit_scan_if bus0 ();
    digit_scan_if bus1 ();

    assign bus1.run        = bus0.run;
    assign bus1.digit_mask = bus0.digit_mask;
    assign bus1.value      = bus0.value;

    digit_scan_ctrl #(.ON_CYC(4), .BLANK_CYC(2), .CNT_W(4)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    digit_scan_ctrl #(.ON_CYC(4), .BLANK_CYC(0), .CNT_W(4)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [3:0] mask, input logic [15:0] val);
        bus0.run = 1'b0;
        step();
        bus0.digit_mask = mask;
        bus0.value      = val;
        bus0.run        = 1'b1;
        step();
    endtask

    // n counts cycles since the first strobe; seq lists enabled digits in scan order.
    task automatic scan_check(input string name, input int n, input logic [7:0] seq,
                              input int nseq, input logic [15:0] val);
        int per, slot, ph;
        logic [1:0] ei;
        logic [3:0] en;
        logic       ee, ef;
        for (int d = 0; d < 2; d++) begin
            per  = (d == 0) ? 6 : 4;
            slot = n / per;
            ph   = n % per;
            ei   = seq[2*(slot % nseq) +: 2];
            en   = val[4*ei +: 4];
            ee   = (ph >= 4);
            ef   = (ph == 0) && (slot > 0) && (slot % nseq == 0);
            if (d == 0) begin
                check($sformatf("%s_d0_n%0d_idx", name, n), {30'd0, bus0.sel_a, bus0.sel_b}, 32'(ei));
                check($sformatf("%s_d0_n%0d_en", name, n), 32'(bus0.sel_e_n), 32'(ee));
                check($sformatf("%s_d0_n%0d_nib", name, n), 32'(bus0.nibble), 32'(en));
                check($sformatf("%s_d0_n%0d_fd", name, n), 32'(bus0.frame_done), 32'(ef));
            end else begin
                check($sformatf("%s_d1_n%0d_idx", name, n), {30'd0, bus1.sel_a, bus1.sel_b}, 32'(ei));
                check($sformatf("%s_d1_n%0d_en", name, n), 32'(bus1.sel_e_n), 32'(ee));
                check($sformatf("%s_d1_n%0d_nib", name, n), 32'(bus1.nibble), 32'(en));
                check($sformatf("%s_d1_n%0d_fd", name, n), 32'(bus1.frame_done), 32'(ef));
            end
        end
    endtask

    initial begin
        bus0.run        = 1'b0;
        bus0.digit_mask = 4'h0;
        bus0.value      = 16'h0;
        #12;
        check("rst_en0", 32'(bus0.sel_e_n), 32'd1);
        check("rst_idx0", {30'd0, bus0.sel_a, bus0.sel_b}, 32'd0);
        check("rst_nib0", 32'(bus0.nibble), 32'd0);
        check("rst_fd0", 32'(bus0.frame_done), 32'd0);
        check("rst_en1", 32'(bus1.sel_e_n), 32'd1);
        #1 rst_n = 1'b1;
        step();
        check("idle_en0", 32'(bus0.sel_e_n), 32'd1);

        // Full mask: 0,1,2,3 then wrap
        start(4'hF, 16'h4321);
        for (int n = 0; n < 26; n++) begin
            scan_check("full", n, 8'b11_10_01_00, 4, 16'h4321);
            step();
        end

        // Sparse mask 1010: 1,3,1,3
        start(4'b1010, 16'hABCD);
        for (int n = 0; n < 25; n++) begin
            scan_check("m1010", n, 8'b00_00_11_01, 2, 16'hABCD);
            step();
        end

        // Single digit 2: every advance wraps
        start(4'b0100, 16'h5E00);
        for (int n = 0; n < 19; n++) begin
            scan_check("single", n, 8'b00_00_00_10, 1, 16'h5E00);
            step();
        end

        // value only sampled at digit entry
        start(4'hF, 16'h4321);
        bus0.value = 16'h8765;
        step();
        check("hold_d0_n1", 32'(bus0.nibble), 32'h1);
        check("hold_d1_n1", 32'(bus1.nibble), 32'h1);
        step(); step(); step();
        check("hold_d1_n4", 32'(bus1.nibble), 32'h6);
        step();
        check("hold_d0_n5", 32'(bus0.nibble), 32'h1);
        step();
        check("hold_d0_n6", 32'(bus0.nibble), 32'h6);

        // run dropped mid-SHOW of idx 2
        start(4'hF, 16'h4321);
        for (int n = 0; n < 13; n++) step();
        check("drop_pre_idx", {30'd0, bus0.sel_a, bus0.sel_b}, 32'd2);
        check("drop_pre_en", 32'(bus0.sel_e_n), 32'd0);
        bus0.run = 1'b0;
        step();
        check("drop_en0", 32'(bus0.sel_e_n), 32'd1);
        check("drop_idx0", {30'd0, bus0.sel_a, bus0.sel_b}, 32'd0);
        check("drop_fd0", 32'(bus0.frame_done), 32'd0);
        check("drop_en1", 32'(bus1.sel_e_n), 32'd1);
        step();
        check("drop_idle_en0", 32'(bus0.sel_e_n), 32'd1);
        bus0.run = 1'b1;
        step();
        check("rerun_en0", 32'(bus0.sel_e_n), 32'd0);
        check("rerun_idx0", {30'd0, bus0.sel_a, bus0.sel_b}, 32'd0);
        check("rerun_nib0", 32'(bus0.nibble), 32'h1);

        // asynchronous reset mid-BLANK of idx 1
        start(4'hF, 16'h4321);
        for (int n = 0; n < 10; n++) step();
        check("blank_idx0", {30'd0, bus0.sel_a, bus0.sel_b}, 32'd1);
        check("blank_en0", 32'(bus0.sel_e_n), 32'd1);
        check("blank_nib0", 32'(bus0.nibble), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_idx0", {30'd0, bus0.sel_a, bus0.sel_b}, 32'd0);
        check("arst_en0", 32'(bus0.sel_e_n), 32'd1);
        check("arst_nib0", 32'(bus0.nibble), 32'h0);
        check("arst_fd0", 32'(bus0.frame_done), 32'd0);
        check("arst_nib1", 32'(bus1.nibble), 32'h0);
        #1 rst_n = 1'b1;
        step();

        // mask cleared while run stays high
        start(4'hF, 16'h4321);
        check("mask_pre_en", 32'(bus0.sel_e_n), 32'd0);
        bus0.digit_mask = 4'h0;
        step();
        check("mask0_en0", 32'(bus0.sel_e_n), 32'd1);
        check("mask0_idx0", {30'd0, bus0.sel_a, bus0.sel_b}, 32'd0);
        check("mask0_en1", 32'(bus1.sel_e_n), 32'd1);
        step(); step();
        check("mask0_hold_en0", 32'(bus0.sel_e_n), 32'd1);
        check("mask0_hold_en1", 32'(bus1.sel_e_n), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
